// File: rtl/usb_rx_pkt_ctrl.sv
// USB full-speed receive packet controller: checks SYNC/PID, forwards PID and data
// bytes to the rx FIFO, enforces length/overflow limits and reports packet status.
module usb_rx_pkt_ctrl #(
    parameter int         MAX_BYTES = 64,
    parameter logic [7:0] SYNC_BYTE = 8'h80,
    localparam int        CW        = $clog2(MAX_BYTES + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          d_edge,
    input  logic          eop,
    input  logic          shift_enable,
    input  logic          byte_received,
    input  logic [7:0]    rcv_data,
    input  logic          fifo_full,
    output logic          rcving,
    output logic          w_enable,
    output logic [7:0]    w_data,
    output logic          r_error,
    output logic [3:0]    pid,
    output logic          pkt_done,
    output logic [CW-1:0] byte_count
);

    typedef enum logic [2:0] {
        IDLE,
        SYNC,
        PID,
        DATA,
        ERR,
        EOP
    } state_t;

    state_t        state_reg, state_next;
    logic [2:0]    bit_cnt_reg;
    logic [CW-1:0] byte_count_reg, byte_count_next;
    logic [3:0]    pid_reg, pid_next;
    logic          r_error_reg, r_error_next;
    logic          w_enable_reg, w_enable_next;
    logic [7:0]    w_data_reg, w_data_next;
    logic          pkt_done_reg, pkt_done_next;
    logic          err_eop_reg, err_eop_next;
    logic          eop_bit;

    assign eop_bit = eop & shift_enable;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg      <= IDLE;
            byte_count_reg <= '0;
            pid_reg        <= '0;
            r_error_reg    <= 1'b0;
            w_enable_reg   <= 1'b0;
            w_data_reg     <= '0;
            pkt_done_reg   <= 1'b0;
            err_eop_reg    <= 1'b0;
        end else begin
            state_reg      <= state_next;
            byte_count_reg <= byte_count_next;
            pid_reg        <= pid_next;
            r_error_reg    <= r_error_next;
            w_enable_reg   <= w_enable_next;
            w_data_reg     <= w_data_next;
            pkt_done_reg   <= pkt_done_next;
            err_eop_reg    <= err_eop_next;
        end
    end

    // Bit position within the current byte; only used to judge EOP alignment.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bit_cnt_reg <= '0;
        end else if (state_reg == IDLE && d_edge) begin
            bit_cnt_reg <= '0;
        end else if (byte_received) begin
            bit_cnt_reg <= '0;
        end else if (shift_enable) begin
            bit_cnt_reg <= bit_cnt_reg + 3'd1;
        end
    end

    always_comb begin
        state_next      = state_reg;
        byte_count_next = byte_count_reg;
        pid_next        = pid_reg;
        r_error_next    = r_error_reg;
        w_enable_next   = 1'b0;
        w_data_next     = w_data_reg;
        pkt_done_next   = 1'b0;
        err_eop_next    = 1'b0;

        case (state_reg)
            IDLE: begin
                if (d_edge) begin
                    state_next      = SYNC;
                    r_error_next    = 1'b0;
                    byte_count_next = '0;
                end
            end
            SYNC: begin
                if (eop_bit) begin
                    state_next   = ERR;
                    err_eop_next = 1'b1;
                end else if (byte_received) begin
                    state_next = (rcv_data == SYNC_BYTE) ? PID : ERR;
                end
            end
            PID: begin
                if (eop_bit) begin
                    state_next   = ERR;
                    err_eop_next = 1'b1;
                end else if (byte_received) begin
                    if (rcv_data[7:4] == ~rcv_data[3:0]) begin
                        state_next    = DATA;
                        pid_next      = rcv_data[3:0];
                        w_enable_next = 1'b1;
                        w_data_next   = rcv_data;
                    end else begin
                        state_next = ERR;
                    end
                end
            end
            DATA: begin
                // An EOP landing on the byte strobe is misaligned; the byte is dropped.
                if (eop_bit) begin
                    if (byte_received || bit_cnt_reg != 3'd0) begin
                        state_next   = ERR;
                        err_eop_next = 1'b1;
                    end else begin
                        state_next = EOP;
                    end
                end else if (byte_received) begin
                    if (fifo_full || byte_count_reg == CW'(MAX_BYTES)) begin
                        state_next = ERR;
                    end else begin
                        w_enable_next   = 1'b1;
                        w_data_next     = rcv_data;
                        byte_count_next = byte_count_reg + CW'(1);
                    end
                end
            end
            ERR: begin
                // The EOP that caused the error still counts once we are in ERR.
                if (eop_bit || (err_eop_reg && eop)) begin
                    state_next = EOP;
                end else begin
                    err_eop_next = err_eop_reg & eop;
                end
            end
            EOP: begin
                if (!eop) begin
                    state_next    = IDLE;
                    pkt_done_next = ~r_error_reg;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        if (state_next == ERR) begin
            r_error_next = 1'b1;
        end
    end

    assign rcving     = (state_reg != IDLE);
    assign w_enable   = w_enable_reg;
    assign w_data     = w_data_reg;
    assign r_error    = r_error_reg;
    assign pid        = pid_reg;
    assign pkt_done   = pkt_done_reg;
    assign byte_count = byte_count_reg;

endmodule
